// File: rtl/regfile_scoreboard_if.sv
// Bundles the read, reserve and writeback ports of the regfile scoreboard.
// The master side is the pipeline; the slave side is the register file.
interface regfile_scoreboard_if #(
  parameter int AW    = 2,
  parameter int WIDTH = 32
);
  logic [AW-1:0]    ra_addr;
  logic [WIDTH-1:0] ra_data;
  logic             ra_busy;
  logic [AW-1:0]    rb_addr;
  logic [WIDTH-1:0] rb_data;
  logic             rb_busy;
  logic             rsv_valid;
  logic [AW-1:0]    rsv_addr;
  logic             rsv_ready;
  logic             wb_valid;
  logic [AW-1:0]    wb_addr;
  logic [WIDTH-1:0] wb_data;
  logic             err;

  modport master (
    output ra_addr, rb_addr, rsv_valid, rsv_addr, wb_valid, wb_addr, wb_data,
    input  ra_data, ra_busy, rb_data, rb_busy, rsv_ready, err
  );

  modport slave (
    input  ra_addr, rb_addr, rsv_valid, rsv_addr, wb_valid, wb_addr, wb_data,
    output ra_data, ra_busy, rb_data, rb_busy, rsv_ready, err
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register file with per-register outstanding-write counters, writeback-to-read
// bypass, optional hardwired-zero r0 and a sticky protocol-error flag.
module regfile_scoreboard #(
  parameter int AW       = 2,
  parameter int WIDTH    = 32,
  parameter int CNT_W    = 2,
  parameter int ZERO_REG = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_scoreboard_if.slave  rf_if
);
  localparam int               NREG    = 2 ** AW;
  localparam logic [CNT_W-1:0] CMAX    = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [NREG-1:0]  ZMASK   = (ZERO_REG != 0) ? NREG'(1) : '0;

  logic [NREG-1:0][WIDTH-1:0] data_q, data_d;
  logic [NREG-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic                       err_q, err_d;

  logic [NREG-1:0] wb_hit;
  logic [NREG-1:0] rsv_acc;
  logic            ra_zero, rb_zero, rsv_zero;
  logic            rsv_ok;

  assign ra_zero  = ZMASK[rf_if.ra_addr];
  assign rb_zero  = ZMASK[rf_if.rb_addr];
  assign rsv_zero = ZMASK[rf_if.rsv_addr];

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      wb_hit[i] = rf_if.wb_valid && (rf_if.wb_addr == AW'(i)) && !ZMASK[i];
    end
  end

  // A writeback in the same cycle frees a slot, so a saturated counter can still accept.
  assign rsv_ok = rsv_zero || (cnt_q[rf_if.rsv_addr] != CMAX) || wb_hit[rf_if.rsv_addr];
  assign rf_if.rsv_ready = rsv_ok;

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      rsv_acc[i] = rf_if.rsv_valid && rsv_ok && (rf_if.rsv_addr == AW'(i)) && !ZMASK[i];
    end
  end

  assign rf_if.ra_data = ra_zero ? '0 :
                         wb_hit[rf_if.ra_addr] ? rf_if.wb_data : data_q[rf_if.ra_addr];
  assign rf_if.rb_data = rb_zero ? '0 :
                         wb_hit[rf_if.rb_addr] ? rf_if.wb_data : data_q[rf_if.rb_addr];

  assign rf_if.ra_busy = !ra_zero &&
                         ((cnt_q[rf_if.ra_addr] > CNT_ONE) ||
                          ((cnt_q[rf_if.ra_addr] == CNT_ONE) && !wb_hit[rf_if.ra_addr]));
  assign rf_if.rb_busy = !rb_zero &&
                         ((cnt_q[rf_if.rb_addr] > CNT_ONE) ||
                          ((cnt_q[rf_if.rb_addr] == CNT_ONE) && !wb_hit[rf_if.rb_addr]));

  assign rf_if.err = err_q;

  always_comb begin
    err_d = err_q;
    for (int i = 0; i < NREG; i++) begin
      data_d[i] = wb_hit[i] ? rf_if.wb_data : data_q[i];
      case ({rsv_acc[i], wb_hit[i] && (cnt_q[i] != '0)})
        2'b10:   cnt_d[i] = cnt_q[i] + CNT_ONE;
        2'b01:   cnt_d[i] = cnt_q[i] - CNT_ONE;
        default: cnt_d[i] = cnt_q[i];
      endcase
      // A writeback with nothing outstanding is a protocol error unless it pairs with a new reservation.
      if (wb_hit[i] && (cnt_q[i] == '0) && !rsv_acc[i]) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end
endmodule
